bus_arbiter4: RTL

//  Round-robin arbiter that shares one 4-input one-hot datapath mux (e.g. the shared data bus) among four requesters.

---
 rtl/bus_arbiter4_pkg.sv | 24 ++
 rtl/bus_arbiter4_pick.sv | 27 ++
 rtl/bus_arbiter4.sv | 110 +++++++++++
 3 files changed

// File: rtl/bus_arbiter4_pkg.sv
// Shared definitions for the four-way round-robin bus arbiter:
// one-hot select codes, FSM state encoding and the index-to-select helper.
package bus_arbiter4_pkg;

    localparam int unsigned NREQ = 4;
    localparam int unsigned PW   = 2;

    localparam logic [NREQ-1:0] SEL_NONE = 4'b0000;
    localparam logic [NREQ-1:0] SEL0     = 4'b0001;
    localparam logic [NREQ-1:0] SEL1     = 4'b0010;
    localparam logic [NREQ-1:0] SEL2     = 4'b0100;
    localparam logic [NREQ-1:0] SEL3     = 4'b1000;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_t;

    // Binary requester index to its one-hot mux select code.
    function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] idx);
        return NREQ'(SEL0 << idx);
    endfunction

endpackage

// File: rtl/bus_arbiter4_pick.sv
// Combinational round-robin picker: first set request scanning
// last_ptr+1, +2, +3, +0 (mod 4).
module rr_pick4
    import bus_arbiter4_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   last_ptr,
    output logic [PW-1:0]   pick,
    output logic            any
);

    logic [PW-1:0] idx;

    always_comb begin
        pick = '0;
        any  = 1'b0;
        idx  = '0;
        for (int k = 1; k <= 4; k++) begin
            idx = PW'(last_ptr + PW'(k));
            if (!any && req[idx]) begin
                pick = idx;
                any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter4.sv
// Round-robin arbiter driving the registered one-hot select of a shared 4:1 bus mux,
// with a bounded hold time per owner while others wait.
module bus_arbiter4
    import bus_arbiter4_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CW       = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] grant,
    output logic            busy,
    output logic [PW-1:0]   owner,
    output logic            preempt
);

    localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

    state_t          state, state_nx;
    logic [NREQ-1:0] grant_nx;
    logic [PW-1:0]   owner_nx;
    logic [PW-1:0]   last_ptr, last_ptr_nx;
    logic [CW-1:0]   hold_cnt, hold_cnt_nx;
    logic            preempt_nx;

    logic [NREQ-1:0] others;
    logic [NREQ-1:0] pick_req;
    logic [PW-1:0]   pick_ptr;
    logic [PW-1:0]   pick;
    logic            pick_any;

    // In OWN the scan starts after the current owner and never includes it.
    assign others   = req & ~grant;
    assign pick_req = (state == ST_OWN) ? others : req;
    assign pick_ptr = (state == ST_OWN) ? owner  : last_ptr;

    rr_pick4 u_pick (
        .req      (pick_req),
        .last_ptr (pick_ptr),
        .pick     (pick),
        .any      (pick_any)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            grant    <= SEL_NONE;
            busy     <= 1'b0;
            owner    <= '0;
            last_ptr <= PW'(3);
            hold_cnt <= '0;
            preempt  <= 1'b0;
        end else begin
            state    <= state_nx;
            grant    <= grant_nx;
            busy     <= (grant_nx != SEL_NONE);
            owner    <= owner_nx;
            last_ptr <= last_ptr_nx;
            hold_cnt <= hold_cnt_nx;
            preempt  <= preempt_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        grant_nx    = grant;
        owner_nx    = owner;
        last_ptr_nx = last_ptr;
        hold_cnt_nx = hold_cnt;
        preempt_nx  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    state_nx    = ST_OWN;
                    grant_nx    = onehot(pick);
                    owner_nx    = pick;
                    hold_cnt_nx = '0;
                end
            end
            ST_OWN: begin
                if (!req[owner]) begin
                    last_ptr_nx = owner;
                    hold_cnt_nx = '0;
                    if (pick_any) begin
                        grant_nx = onehot(pick);
                        owner_nx = pick;
                    end else begin
                        state_nx = ST_IDLE;
                        grant_nx = SEL_NONE;
                    end
                end else if (pick_any && hold_cnt == HOLD_LAST) begin
                    last_ptr_nx = owner;
                    grant_nx    = onehot(pick);
                    owner_nx    = pick;
                    hold_cnt_nx = '0;
                    preempt_nx  = 1'b1;
                end else if (hold_cnt != HOLD_LAST) begin
                    hold_cnt_nx = hold_cnt + CW'(1);
                end
            end
            default: begin
                state_nx = ST_IDLE;
                grant_nx = SEL_NONE;
            end
        endcase
    end

endmodule
